can_opb_master: RTL and testbench

CAN_OPB_MASTER -- requirements
Module: can_opb_master

---
 rtl/can_opb_master.sv | 175 +++++++++++++++++
 tb/tb_can_opb_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_opb_master.sv
// can_opb_master
//   Single-outstanding OPB master for a four-channel CAN_IF block.
//   It accepts a request, then drives a one-cycle read or write strobe to
//   one channel. Read data is captured READ_LAT cycles after the read
//   strobe. The completion is then held until the consumer takes it.
//
//   state   | meaning
//   IDLE    | ready for a request (REQ_READY high)
//   WR_STB  | CANx_WE high for the latched channel
//   RD_STB  | CANx_RE high for the latched channel
//   RD_WAIT | counting down the remaining read latency
//   RSP     | completion presented (RSP_VALID high)
//
// Ports
//   OPB_CLK, OPB_RST_N        clock, async active-low reset
//   REQ_*                     request handshake and fields (wr, ch, ofs, wdata)
//   RSP_*                     completion handshake, wr echo, read data
//   OPB_ADDR, OPB_DO          bus address / write data to CAN_IF
//   CANx_RE, CANx_WE          per-channel read/write strobes
//   CANx_DO                   per-channel read data from CAN_IF
module can_opb_master #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [1:0]  REQ_CH,
  input  logic [10:0] REQ_OFS,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_WR,
  output logic [31:0] RSP_RDATA,
  output logic [15:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        CAN1_RE,
  output logic        CAN2_RE,
  output logic        CAN3_RE,
  output logic        CAN4_RE,
  output logic        CAN1_WE,
  output logic        CAN2_WE,
  output logic        CAN3_WE,
  output logic        CAN4_WE,
  input  logic [31:0] CAN1_DO,
  input  logic [31:0] CAN2_DO,
  input  logic [31:0] CAN3_DO,
  input  logic [31:0] CAN4_DO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_STB,
    S_RD_STB,
    S_RD_WAIT,
    S_RSP
  } state_t;

  // RD_STB already accounts for one cycle of latency, so RD_WAIT counts the
  // remaining READ_LAT-1 cycles; the load value reaching zero means the
  // next edge is the sample edge.
  localparam logic [3:0] LAT_LOAD = (READ_LAT >= 2) ? 4'(READ_LAT - 2) : 4'd0;

  state_t      state;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_wr_q;
  logic [31:0] rsp_rdata_q;
  logic [15:0] opb_addr_q;
  logic [31:0] opb_do_q;
  logic [3:0]  re_q;
  logic [3:0]  we_q;
  logic [1:0]  ch_q;
  logic [3:0]  lat_cnt;
  logic [31:0] sel_do;

  always_comb begin
    sel_do = CAN1_DO;
    case (ch_q)
      2'd0:    sel_do = CAN1_DO;
      2'd1:    sel_do = CAN2_DO;
      2'd2:    sel_do = CAN3_DO;
      default: sel_do = CAN4_DO;
    endcase
  end

  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state       <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      opb_addr_q  <= '0;
      opb_do_q    <= '0;
      re_q        <= '0;
      we_q        <= '0;
      ch_q        <= '0;
      lat_cnt     <= '0;
    end else begin
      // strobes are single-cycle pulses set only at acceptance
      re_q <= '0;
      we_q <= '0;
      case (state)
        S_IDLE: begin
          if (REQ_VALID && req_ready_q) begin
            req_ready_q <= 1'b0;
            ch_q        <= REQ_CH;
            rsp_wr_q    <= REQ_WR;
            rsp_rdata_q <= '0;
            opb_addr_q  <= {1'b0, 4'b0001 << REQ_CH, REQ_OFS};
            if (REQ_WR) begin
              opb_do_q     <= REQ_WDATA;
              we_q[REQ_CH] <= 1'b1;
              state        <= S_WR_STB;
            end else begin
              re_q[REQ_CH] <= 1'b1;
              state        <= S_RD_STB;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WR_STB: begin
          rsp_valid_q <= 1'b1;
          state       <= S_RSP;
        end
        S_RD_STB: begin
          if (READ_LAT == 1) begin
            rsp_rdata_q <= sel_do;
            rsp_valid_q <= 1'b1;
            state       <= S_RSP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (lat_cnt == 4'd0) begin
            rsp_rdata_q <= sel_do;
            rsp_valid_q <= 1'b1;
            state       <= S_RSP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_RSP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_WR    = rsp_wr_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign OPB_ADDR  = opb_addr_q;
  assign OPB_DO    = opb_do_q;
  assign CAN1_RE   = re_q[0];
  assign CAN2_RE   = re_q[1];
  assign CAN3_RE   = re_q[2];
  assign CAN4_RE   = re_q[3];
  assign CAN1_WE   = we_q[0];
  assign CAN2_WE   = we_q[1];
  assign CAN3_WE   = we_q[2];
  assign CAN4_WE   = we_q[3];

endmodule

// File: tb/tb_can_opb_master.sv
// tb_can_opb_master
//   Three instances (READ_LAT = 2, 1, 4) share one stimulus stream. Each has
//   a transaction-timeline model (acceptance cycle plus latency arithmetic)
//   checked every cycle; directed sequences on the READ_LAT=2 instance carry
//   hand-computed literal expectations.
module tb_can_opb_master;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_ch;
  logic [10:0] req_ofs;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic [31:0] do_v [4];

  logic        req_ready_s [NI];
  logic        rsp_valid_s [NI];
  logic        rsp_wr_s    [NI];
  logic [31:0] rsp_rdata_s [NI];
  logic [15:0] addr_s      [NI];
  logic [31:0] odo_s       [NI];
  logic [3:0]  re_s        [NI];
  logic [3:0]  we_s        [NI];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    can_opb_master #(.READ_LAT(LAT)) u_dut (
      .OPB_CLK   (clk),
      .OPB_RST_N (rst_n),
      .REQ_VALID (req_valid),
      .REQ_READY (req_ready_s[g]),
      .REQ_WR    (req_wr),
      .REQ_CH    (req_ch),
      .REQ_OFS   (req_ofs),
      .REQ_WDATA (req_wdata),
      .RSP_VALID (rsp_valid_s[g]),
      .RSP_READY (rsp_ready),
      .RSP_WR    (rsp_wr_s[g]),
      .RSP_RDATA (rsp_rdata_s[g]),
      .OPB_ADDR  (addr_s[g]),
      .OPB_DO    (odo_s[g]),
      .CAN1_RE   (re_s[g][0]),
      .CAN2_RE   (re_s[g][1]),
      .CAN3_RE   (re_s[g][2]),
      .CAN4_RE   (re_s[g][3]),
      .CAN1_WE   (we_s[g][0]),
      .CAN2_WE   (we_s[g][1]),
      .CAN3_WE   (we_s[g][2]),
      .CAN4_WE   (we_s[g][3]),
      .CAN1_DO   (do_v[0]),
      .CAN2_DO   (do_v[1]),
      .CAN3_DO   (do_v[2]),
      .CAN4_DO   (do_v[3])
    );

    // Model: one transaction at a time; everything is derived from the
    // acceptance cycle 'acc' and the current edge count 'tick'.
    int          tick = 0;
    int          acc  = 0;
    bit          busy, ready_m, wr_m, vld_m;
    logic [1:0]  ch_m;
    logic [15:0] addr_m;
    logic [31:0] do_m, rdata_m;
    logic [7:0]  stb_exp;

    always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy = 0; ready_m = 0; wr_m = 0; vld_m = 0; ch_m = 0;
        addr_m = 0; do_m = 0; rdata_m = 0;
      end else begin
        tick++;
        if (busy && vld_m && rsp_ready) begin
          busy = 0;
        end else if (!busy && ready_m && req_valid) begin
          busy    = 1;
          acc     = tick;
          wr_m    = req_wr;
          ch_m    = req_ch;
          addr_m  = (16'h0800 << req_ch) | {5'b0, req_ofs};
          rdata_m = 0;
          if (req_wr) do_m = req_wdata;
        end
        if (busy && !wr_m && tick == acc + LAT) rdata_m = do_v[ch_m];
        ready_m = !busy;
        vld_m   = busy && (tick >= acc + (wr_m ? 1 : LAT));
      end
      stb_exp = 8'h00;
      if (rst_n && busy && tick == acc)
        stb_exp = wr_m ? (8'h10 << ch_m) : (8'h01 << ch_m);
      #1;
      chk($sformatf("i%0d_req_ready", g), 32'(req_ready_s[g]), 32'(ready_m));
      chk($sformatf("i%0d_rsp_valid", g), 32'(rsp_valid_s[g]), 32'(vld_m));
      chk($sformatf("i%0d_strobes", g), 32'({we_s[g], re_s[g]}), 32'(stb_exp));
      chk($sformatf("i%0d_strobe_count_gt1", g), 32'($countones({we_s[g], re_s[g]}) > 1), 32'd0);
      chk($sformatf("i%0d_opb_addr", g), 32'(addr_s[g]), 32'(addr_m));
      chk($sformatf("i%0d_opb_do", g), odo_s[g], do_m);
      if (!rst_n || vld_m) begin
        chk($sformatf("i%0d_rsp_wr", g), 32'(rsp_wr_s[g]), 32'(rst_n ? wr_m : 1'b0));
        chk($sformatf("i%0d_rsp_rdata", g), rsp_rdata_s[g], rdata_m);
      end
    end
  end

  // Waits (from a negedge) until instance 0 is ready, then lets the accepting
  // edge pass; returns #2 after that edge with the acceptance cycle number.
  task automatic wait_accept(output int t);
    int n = 0;
    while (!req_ready_s[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk);
    #2;
    t = cyc;
  endtask

  task automatic set_req(input logic wr, input logic [1:0] ch, input logic [10:0] ofs,
                         input logic [31:0] wd);
    req_valid = 1'b1;
    req_wr    = wr;
    req_ch    = ch;
    req_ofs   = ofs;
    req_wdata = wd;
  endtask

  initial begin
    int t1, t2, ta;
    rst_n = 1'b0; req_valid = 0; req_wr = 0; req_ch = 0; req_ofs = 0; req_wdata = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_v[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_s[0]), 32'd0);
    chk("rst_opb_addr", 32'(addr_s[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_s[0], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_reset", 32'(req_ready_s[0]), 32'd1);

    // write ch0
    @(negedge clk);
    set_req(1'b1, 2'd0, 11'h000, 32'h12345678);
    wait_accept(ta);
    chk("wr0_addr", 32'(addr_s[0]), 32'h0800);
    chk("wr0_do", odo_s[0], 32'h12345678);
    chk("wr0_we", 32'(we_s[0]), 32'h1);
    chk("wr0_re", 32'(re_s[0]), 32'h0);
    @(negedge clk); req_valid = 0;
    @(posedge clk); #2;
    chk("wr0_we_off", 32'(we_s[0]), 32'h0);
    chk("wr0_rsp_valid", 32'(rsp_valid_s[0]), 32'd1);
    chk("wr0_rsp_wr", 32'(rsp_wr_s[0]), 32'd1);
    chk("wr0_rsp_rdata", rsp_rdata_s[0], 32'd0);

    // read ch2 ofs 4
    @(negedge clk);
    do_v[2] = 32'h55AA55AA;
    set_req(1'b0, 2'd2, 11'h004, 32'hFFFF0000);
    wait_accept(ta);
    chk("rd2_addr", 32'(addr_s[0]), 32'h2004);
    chk("rd2_re", 32'(re_s[0]), 32'h4);
    chk("rd2_do_kept", odo_s[0], 32'h12345678);
    @(negedge clk); req_valid = 0;
    @(posedge clk); #2;
    chk("rd2_re_off", 32'(re_s[0]), 32'h0);
    chk("rd2_not_yet_valid", 32'(rsp_valid_s[0]), 32'd0);
    @(posedge clk); #2;
    chk("rd2_rsp_valid", 32'(rsp_valid_s[0]), 32'd1);
    chk("rd2_rsp_rdata", rsp_rdata_s[0], 32'h55AA55AA);

    // read ch3 ofs 7FF with data changing after the sample edge; hold RSP_READY low
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    do_v[3] = 32'hDEADBEEF;
    set_req(1'b0, 2'd3, 11'h7FF, 32'h0);
    wait_accept(ta);
    chk("rd3_addr", 32'(addr_s[0]), 32'h47FF);
    @(negedge clk);
    set_req(1'b1, 2'd1, 11'h010, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); do_v[3] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk($sformatf("hold%0d_rsp_valid", i), 32'(rsp_valid_s[0]), 32'd1);
      chk($sformatf("hold%0d_rsp_rdata", i), rsp_rdata_s[0], 32'hDEADBEEF);
      chk($sformatf("hold%0d_req_ready", i), 32'(req_ready_s[0]), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    wait_accept(t1);
    chk("wr1_we", 32'(we_s[0]), 32'h2);
    chk("wr1_do", odo_s[0], 32'hCAFEF00D);
    chk("wr1_addr", 32'(addr_s[0]), 32'h1010);

    // back-to-back write to ch3
    @(negedge clk);
    set_req(1'b1, 2'd3, 11'h020, 32'h0BADCAFE);
    wait_accept(t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd3);
    chk("b2b_we", 32'(we_s[0]), 32'h8);
    @(negedge clk); req_valid = 0;

    // reset while RE is high
    @(negedge clk);
    set_req(1'b0, 2'd1, 11'h008, 32'h0);
    wait_accept(ta);
    chk("rstre_re_before", 32'(re_s[0]), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rstre_re_dropped", 32'(re_s[0]), 32'h0);
    req_valid = 0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;

    // reset during RD_WAIT
    @(negedge clk);
    set_req(1'b0, 2'd0, 11'h00C, 32'h0);
    wait_accept(ta);
    @(negedge clk); req_valid = 0;
    @(posedge clk); #2;
    chk("rdwait_re_off", 32'(re_s[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rdwait_rst_valid", 32'(rsp_valid_s[0]), 32'd0);
    @(posedge clk); #2;
    chk("rdwait_rst_valid_later", 32'(rsp_valid_s[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_v[1] = 32'h13579BDF;
    set_req(1'b0, 2'd1, 11'h100, 32'h0);
    wait_accept(ta);
    chk("post_rst_addr", 32'(addr_s[0]), 32'h1100);
    @(negedge clk); req_valid = 0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("post_rst_valid", 32'(rsp_valid_s[0]), 32'd1);
    chk("post_rst_rdata", rsp_rdata_s[0], 32'h13579BDF);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 199) != 0);
      req_valid = $urandom_range(0, 1);
      req_wr    = $urandom_range(0, 1);
      req_ch    = 2'($urandom_range(0, 3));
      req_ofs   = 11'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 4; k++) do_v[k] = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 0; rsp_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
